// File: rtl/fetch_unit.sv
// Sequential instruction fetch: one outstanding read with one-cycle memory latency,
// a two-entry {pc, instr} FIFO towards the consumer, redirect flush and miss replay.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef IMEM_ADDR_WIDTH
`define IMEM_ADDR_WIDTH 10
`endif

module fetch_unit #(
  parameter int          DATA_WIDTH = `DATA_WIDTH,
  parameter int          ADDR_WIDTH = `IMEM_ADDR_WIDTH,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_address,
  input  logic [DATA_WIDTH-1:0] imem_read_data,
  input  logic                  imem_read_data_valid,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [31:0]           instr_pc,
  input  logic                  instr_ready
);

  logic [31:0]           fetch_pc_r;
  logic [31:0]           fetch_pc_s;
  logic                  inflight_r;
  logic                  inflight_s;
  logic [31:0]           inflight_pc_r;
  logic [31:0]           inflight_pc_s;

  logic                  head_valid_r;
  logic                  head_valid_s;
  logic [31:0]           head_pc_r;
  logic [31:0]           head_pc_s;
  logic [DATA_WIDTH-1:0] head_instr_r;
  logic [DATA_WIDTH-1:0] head_instr_s;
  logic                  tail_valid_r;
  logic                  tail_valid_s;
  logic [31:0]           tail_pc_r;
  logic [31:0]           tail_pc_s;
  logic [DATA_WIDTH-1:0] tail_instr_r;
  logic [DATA_WIDTH-1:0] tail_instr_s;

  logic                  pop_s;
  logic                  push_s;
  logic                  miss_s;
  logic                  issue_s;
  logic [1:0]            occupancy_s;

  assign imem_address = fetch_pc_r[ADDR_WIDTH+1:2];
  assign instr_valid  = head_valid_r;
  assign instr        = head_instr_r;
  assign instr_pc     = head_pc_r;

  // Per-cycle transfer, response and issue qualifiers.
  always_comb begin
    pop_s       = head_valid_r & instr_ready;
    push_s      = 1'b0;
    miss_s      = 1'b0;
    issue_s     = 1'b0;
    // buffered + outstanding slots still owed after this cycle's pop; never exceeds 2
    occupancy_s = ({1'b0, head_valid_r} + {1'b0, tail_valid_r} + {1'b0, inflight_r})
                  - {1'b0, pop_s};
    if (redirect_valid) begin
      issue_s = 1'b0;
    end else begin
      push_s  = inflight_r & imem_read_data_valid;
      miss_s  = inflight_r & ~imem_read_data_valid;
      // a dropped response rewinds fetch_pc, so nothing newer may be issued alongside it
      issue_s = ~miss_s & (occupancy_s < 2'd2);
    end
  end

  // Next fetch address and outstanding-read tracking.
  always_comb begin
    fetch_pc_s    = fetch_pc_r;
    inflight_s    = 1'b0;
    inflight_pc_s = inflight_pc_r;
    if (redirect_valid) begin
      fetch_pc_s = redirect_pc & 32'hFFFF_FFFC;
      inflight_s = 1'b0;
    end else if (miss_s) begin
      fetch_pc_s = inflight_pc_r;
      inflight_s = 1'b0;
    end else if (issue_s) begin
      fetch_pc_s    = fetch_pc_r + 32'd4;
      inflight_s    = 1'b1;
      inflight_pc_s = fetch_pc_r;
    end else begin
      inflight_s = 1'b0;
    end
  end

  // Next FIFO contents; the head entry always drives the consumer outputs.
  always_comb begin
    head_valid_s = head_valid_r;
    head_pc_s    = head_pc_r;
    head_instr_s = head_instr_r;
    tail_valid_s = tail_valid_r;
    tail_pc_s    = tail_pc_r;
    tail_instr_s = tail_instr_r;
    if (redirect_valid) begin
      head_valid_s = 1'b0;
      tail_valid_s = 1'b0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (!head_valid_r) begin
            head_valid_s = 1'b1;
            head_pc_s    = inflight_pc_r;
            head_instr_s = imem_read_data;
          end else begin
            tail_valid_s = 1'b1;
            tail_pc_s    = inflight_pc_r;
            tail_instr_s = imem_read_data;
          end
        end
        2'b01: begin
          head_valid_s = tail_valid_r;
          head_pc_s    = tail_pc_r;
          head_instr_s = tail_instr_r;
          tail_valid_s = 1'b0;
        end
        2'b11: begin
          if (tail_valid_r) begin
            head_pc_s    = tail_pc_r;
            head_instr_s = tail_instr_r;
            tail_pc_s    = inflight_pc_r;
            tail_instr_s = imem_read_data;
          end else begin
            head_pc_s    = inflight_pc_r;
            head_instr_s = imem_read_data;
          end
        end
        default: begin
          head_valid_s = head_valid_r;
          tail_valid_s = tail_valid_r;
        end
      endcase
    end
  end

  // State registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= 32'h0000_0000;
      head_valid_r  <= 1'b0;
      head_pc_r     <= 32'h0000_0000;
      head_instr_r  <= {DATA_WIDTH{1'b0}};
      tail_valid_r  <= 1'b0;
      tail_pc_r     <= 32'h0000_0000;
      tail_instr_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      fetch_pc_r    <= fetch_pc_s;
      inflight_r    <= inflight_s;
      inflight_pc_r <= inflight_pc_s;
      head_valid_r  <= head_valid_s;
      head_pc_r     <= head_pc_s;
      head_instr_r  <= head_instr_s;
      tail_valid_r  <= tail_valid_s;
      tail_pc_r     <= tail_pc_s;
      tail_instr_r  <= tail_instr_s;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default `DATA_WIDTH (32), meaning instruction width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default `IMEM_ADDR_WIDTH, meaning the instruction-memory word-address width.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch byte address.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state on rising edge.
REQ-005 The block SHALL have port rst, input, width 1: reset, asynchronous and active-high.
REQ-006 The block SHALL have port imem_address, output, width ADDR_WIDTH: word address, equal to fetch_pc[ADDR_WIDTH+1:2].
REQ-007 The block SHALL have port imem_read_data, input, width DATA_WIDTH: word for the address presented in the previous cycle.
REQ-008 The block SHALL have port imem_read_data_valid, input, width 1: response qualifier.
REQ-009 The block SHALL have port redirect_valid, input, width 1: one-cycle pulse requesting fetch restart.
REQ-010 The block SHALL have port redirect_pc, input, width 32: restart byte address.
REQ-011 The block SHALL have port instr_valid, output, width 1: instr and instr_pc hold a valid instruction.
REQ-012 The block SHALL have port instr, output, width DATA_WIDTH: fetched instruction.
REQ-013 The block SHALL have port instr_pc, output, width 32: byte address of instr.
REQ-014 The block SHALL have port instr_ready, input, width 1: consumer accepts the instruction; transfer occurs when instr_valid and instr_ready are both high.

Function
REQ-015 State: fetch_pc (32b), inflight bit plus inflight_pc, and a 2-entry FIFO of {pc, instr}; instr, instr_pc and instr_valid SHALL come from the FIFO head register.
REQ-016 Memory latency: a read issued in cycle N SHALL be sampled from imem_read_data in cycle N+1.
REQ-017 Define pop = instr_valid && instr_ready; the block SHALL issue in a cycle iff (count + inflight - pop) < 2 and redirect_valid is low.
REQ-018 On issue: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4; otherwise fetch_pc SHALL hold, and imem_address still tracks fetch_pc.
REQ-019 Response cycle (inflight=1), imem_read_data_valid=1: {inflight_pc, imem_read_data} SHALL be pushed; inflight clears unless a new issue occurs in the same cycle.
REQ-020 Response cycle, imem_read_data_valid=0: no push; fetch_pc <= inflight_pc, and the same address SHALL be reissued subject to REQ-017 (no skip, no duplicate).
REQ-021 Push and pop in the same cycle SHALL leave count unchanged with FIFO order preserved; count never exceeds 2 and never underflows.
REQ-022 Issue-to-instr_valid latency SHALL be 2 cycles; with instr_ready held high, steady-state throughput SHALL be 1 instruction/cycle.
REQ-023 instr_valid SHALL stay high and instr/instr_pc stable until pop.
REQ-024 Redirect: with redirect_valid=1 in cycle R, the block SHALL clear the FIFO and squash any response arriving in R+1 (inflight <= 0), set fetch_pc <= {redirect_pc[31:2], 2'b00}, and not issue in R; instr_valid SHALL be 0 in R+1.
REQ-025 Redirect SHALL take priority over a simultaneous pop, push or issue; a pop in cycle R still counts as a completed transfer to the consumer.
REQ-026 After a redirect, the first issue SHALL occur in R+1 and its instruction SHALL be presented with instr_valid in R+3.
REQ-027 fetch_pc SHALL wrap modulo 2^32; imem_address therefore wraps modulo 2^ADDR_WIDTH words.

Reset
REQ-028 While rst=1, fetch_pc SHALL be RESET_PC, inflight=0, count=0, instr_valid=0, instr=0, instr_pc=0, and imem_address=RESET_PC[ADDR_WIDTH+1:2].
REQ-029 Reset asserted mid-operation SHALL immediately discard all inflight and buffered instructions; the first issue after deassertion SHALL occur on the first clock edge with rst low.

Verification
REQ-030 Bench: reset release, imem word k = 0x1000_0000+k, instr_ready=1 -> instr_valid 2 cycles after the first issue; instr_pc 0x0,0x4,0x8... with instr 0x1000_0000,... on consecutive cycles.
REQ-031 Bench: instr_ready=0 for 5 cycles -> exactly 2 entries buffered, fetch_pc stalls at 0x8, no lost or duplicated instruction after release.
REQ-032 Bench: redirect_pc=0x0000_0042 during streaming -> instructions from 0x40 appear 3 cycles later, and nothing from the old stream appears after the redirect cycle.
REQ-033 Bench: imem_read_data_valid=0 for one response at pc 0xC -> 0xC reissued, delivered once, order intact.
REQ-034 Bench: simultaneous redirect_valid and pop -> popped instruction counted once, FIFO empty next cycle.
REQ-035 Bench: rst pulse with count=2 and inflight=1 -> instr_valid=0 asynchronously, refetch begins at RESET_PC.
